tex_mem_responder: RTL and testbench
====================================

TEX_MEM_RESPONDER -- requirements
Module: tex_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 128-bit texel words in backing store.
REQ-002 SHALL have parameter LATENCY, default 2, request-accept-to-ack delay in cycles; legal range 1..15.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mem_req  input  1  read request, held high by requester until ack.
REQ-007 SHALL have port mem_addr  input  32  byte address of 16-byte texel block.
REQ-008 SHALL have port mem_data  output  128  read data, valid only while mem_ack=1.
REQ-009 SHALL have port mem_ack  output  1  one-cycle response pulse.
REQ-010 SHALL have port mem_err  output  1  one-cycle pulse coincident with mem_ack on out-of-range access.
REQ-011 SHALL have port fill_en  input  1  host texture-load write strobe.
REQ-012 SHALL have port fill_idx  input  $clog2(DEPTH)  word index for fill write.
REQ-013 SHALL have port fill_data  input  128  fill write data.
REQ-014 SHALL have port busy  output  1  high while a request is accepted and not yet acked.
REQ-015 SHALL have port served_cnt  output  16  count of acks issued, wraps 16'hFFFF -> 0.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-017 IDLE: mem_req=1 at a rising edge SHALL latch mem_addr, load latency counter with LATENCY-1, go to WAIT (or ACK directly if LATENCY=1).
REQ-018 WAIT: counter SHALL decrement each cycle; at zero go to ACK; mem_req is ignored while in WAIT.
REQ-019 ACK: mem_ack=1 and mem_data driven for exactly one cycle, then return to IDLE; total edges from accept to ack = LATENCY.
REQ-020 Word index SHALL be (latched_addr - BASE_ADDR) >> 4, 32-bit unsigned subtraction; addr[3:0] ignored.
REQ-021 Address below BASE_ADDR (subtraction wraps) or index >= DEPTH SHALL be out-of-range: mem_data=128'hDEAD_BEEF repeated x4, mem_err=1; store untouched.
REQ-022 Read data SHALL be sampled from the store on the edge entering ACK.
REQ-023 fill_en=1 SHALL write fill_data to fill_idx at that edge in any state; fill_idx >= DEPTH SHALL be dropped silently.
REQ-024 Fill to the same index on the edge entering ACK SHALL be forwarded: mem_data equals the new fill_data (write-first).
REQ-025 mem_req held high through ACK SHALL be accepted as a new request on the first IDLE cycle (back-to-back period LATENCY+1 cycles).
REQ-026 mem_req dropped while in WAIT SHALL NOT abort; ack still issues (requester protocol forbids this, no error flagged).
REQ-027 busy SHALL be 1 in WAIT and ACK, 0 in IDLE.
REQ-028 served_cnt SHALL increment once per ack, including error acks.
REQ-029 mem_data SHALL hold 0 when mem_ack=0.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, mem_ack=0, mem_err=0, mem_data=0, busy=0, served_cnt=0, latency counter 0.
REQ-031 Reset mid-request SHALL discard the request with no ack; store contents are not reset.
REQ-032 First request SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-033 Fill idx 5 with 128'h0123...CDEF, req addr BASE+0x50, LATENCY=2 -> mem_ack high exactly 2 edges after accept, mem_data=fill value, mem_err=0, served_cnt=1.
REQ-034 Req addr BASE+DEPTH*16 -> ack after LATENCY, mem_data=DEADBEEF x4, mem_err=1; req addr BASE-16 -> same.
REQ-035 mem_req held high for 3 requests, LATENCY=2 -> acks spaced 3 cycles apart, served_cnt=3, busy low 1 cycle between.
REQ-036 Fill idx 7 with A earlier, fill idx 7 with B on the edge entering ACK for read of idx 7 -> mem_data=B.
REQ-037 rst_n low during WAIT -> no ack, busy=0, served_cnt=0; subsequent read of previously filled idx returns pre-reset data.
REQ-038 Read of addr BASE+0x5F -> same data as BASE+0x50 (low nibble ignored).

Source files
------------

// File: rtl/tex_mem_responder.sv
// Texture memory responder: a 128-bit word store loaded by the host through a
// fill port, and a single-outstanding read port that answers each request with
// a one-cycle ack a fixed LATENCY edges after accept. Addresses outside the
// window [BASE_ADDR, BASE_ADDR + DEPTH*16) return a poison word and mem_err.
module tex_mem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_req,
  input  logic [31:0]              mem_addr,
  output logic [127:0]             mem_data,
  output logic                     mem_ack,
  output logic                     mem_err,
  input  logic                     fill_en,
  input  logic [$clog2(DEPTH)-1:0] fill_idx,
  input  logic [127:0]             fill_data,
  output logic                     busy,
  output logic [15:0]              served_cnt
);

  localparam int           IW       = $clog2(DEPTH);
  localparam logic [127:0] ERR_WORD = {4{32'hDEAD_BEEF}};

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [31:0]   addr_reg, addr_next;
  logic          enter_ack;

  logic [127:0]  store [DEPTH];
  logic [127:0]  rd_word_reg;
  logic [127:0]  fwd_data_reg;
  logic          fwd_reg;

  logic [31:0]   look_addr;
  logic [31:0]   offset;
  logic [27:0]   word;
  logic          look_err;
  logic [IW-1:0] look_idx;

  // Address decode; in IDLE the live address is used so LATENCY=1 works.
  always_comb begin
    look_addr = (state_reg == IDLE) ? mem_addr : addr_reg;
    offset    = look_addr - BASE_ADDR;
    word      = offset[31:4];
    look_err  = (look_addr < BASE_ADDR) || ({4'b0000, word} >= 32'(DEPTH));
    look_idx  = word[IW-1:0];
  end

  // Next-state logic; enter_ack marks the edge that moves into ACK.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    enter_ack  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_req) begin
          addr_next = mem_addr;
          cnt_next  = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_next = ACK;
            enter_ack  = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        // The edge that takes the counter to zero is the edge entering ACK.
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) begin
          state_next = ACK;
          enter_ack  = 1'b1;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, latency counter and latched request address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
    end
  end

  // Backing store with registered read; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (fill_en && (32'(fill_idx) < 32'(DEPTH))) begin
      store[fill_idx] <= fill_data;
    end
    if (enter_ack) begin
      rd_word_reg  <= store[look_idx];
      fwd_data_reg <= fill_data;
    end
  end

  // Response flags and ack counter; a same-edge fill to the read index wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack    <= 1'b0;
      mem_err    <= 1'b0;
      fwd_reg    <= 1'b0;
      served_cnt <= 16'd0;
    end else begin
      mem_ack <= enter_ack;
      mem_err <= enter_ack && look_err;
      fwd_reg <= enter_ack && fill_en && !look_err && (fill_idx == look_idx);
      if (enter_ack) begin
        served_cnt <= served_cnt + 16'd1;
      end
    end
  end

  // Data is only meaningful during the ack cycle and reads zero otherwise.
  always_comb begin
    mem_data = 128'd0;
    if (mem_ack) begin
      if (mem_err) begin
        mem_data = ERR_WORD;
      end else if (fwd_reg) begin
        mem_data = fwd_data_reg;
      end else begin
        mem_data = rd_word_reg;
      end
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_tex_mem_responder.sv
// Scoreboard bench for tex_mem_responder: the driver predicts each response
// from an array model of the store and pushes it; a negedge monitor pops and
// compares whenever mem_ack is seen.
module tb_tex_mem_responder;

  localparam int          DEPTH = 48;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          IW    = $clog2(DEPTH);

  logic           clk;
  logic           rst_n;
  logic           mem_req;
  logic [31:0]    mem_addr;
  logic [127:0]   mem_data;
  logic           mem_ack;
  logic           mem_err;
  logic           fill_en;
  logic [IW-1:0]  fill_idx;
  logic [127:0]   fill_data;
  logic           busy;
  logic [15:0]    served_cnt;

  tex_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ack(mem_ack), .mem_err(mem_err),
    .fill_en(fill_en), .fill_idx(fill_idx), .fill_data(fill_data),
    .busy(busy), .served_cnt(served_cnt)
  );

  typedef struct {
    logic [127:0] data;
    logic         err;
    logic [15:0]  cnt;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] ref_mem [DEPTH];
  logic [15:0]  ref_cnt;
  int           cyc;
  int           n_checks;
  int           n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model: words are 16 bytes starting at BASE; anything else is poisoned.
  function automatic logic [127:0] ref_read(input logic [31:0] a, output logic err);
    if (a < BASE || (a - BASE) / 16 >= DEPTH) begin
      err = 1'b1;
      return {4{32'hDEAD_BEEF}};
    end
    err = 1'b0;
    return ref_mem[(a - BASE) / 16];
  endfunction

  // Advance one edge; a fill driven for that edge lands in the model too.
  task automatic step();
    @(posedge clk);
    #1;
    if (fill_en && (int'(fill_idx) < DEPTH)) ref_mem[fill_idx] = fill_data;
    fill_en = 1'b0;
  endtask

  // One read transaction; optional fill to the read index on the ack edge.
  task automatic do_read(input logic [31:0] a, input bit hold, input bit fwd,
                         input logic [127:0] fwd_val, input bit rnd);
    exp_t e;
    logic err;
    int   acc;
    mem_req  = 1'b1;
    mem_addr = a;
    step();
    acc = cyc;
    check("busy_after_accept", {127'd0, busy}, 128'd1);
    if (!hold) begin
      mem_req  = 1'b0;
      mem_addr = $urandom;
    end
    for (int k = 1; k < LAT; k++) begin
      if (k == LAT - 1 && fwd) begin
        fill_en   = 1'b1;
        fill_idx  = IW'((a - BASE) / 16);
        fill_data = fwd_val;
      end else if (rnd && $urandom_range(0, 1) == 1) begin
        fill_en   = 1'b1;
        fill_idx  = IW'($urandom_range(0, DEPTH - 1));
        fill_data = rand128();
      end
      step();
    end
    e.data = ref_read(a, err);
    e.err  = err;
    ref_cnt++;
    e.cnt  = ref_cnt;
    e.cyc  = acc + LAT - 1;
    sb.push_back(e);
    step();
    check("busy_back_in_idle", {127'd0, busy}, 128'd0);
  endtask

  // Monitor: compare every ack against the oldest prediction.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (mem_ack) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          check("ack_data", mem_data, e.data);
          check("ack_err", {127'd0, mem_err}, {127'd0, e.err});
          check("served_cnt", {112'd0, served_cnt}, {112'd0, e.cnt});
          check("ack_cycle", 128'(cyc), 128'(e.cyc));
        end
      end else begin
        check("idle_outputs_zero", {mem_err, mem_data[126:0]} | {127'd0, mem_data[127]}, 128'd0);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] a;
    bit          hold;
    int          sel;
    n_checks  = 0;
    n_pass    = 0;
    ref_cnt   = 16'd0;
    rst_n     = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = 32'd0;
    fill_en   = 1'b0;
    fill_idx  = '0;
    fill_data = 128'd0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_ack", {127'd0, mem_ack}, 128'd0);
    check("reset_data", mem_data, 128'd0);
    check("reset_served_cnt", {112'd0, served_cnt}, 128'd0);
    rst_n = 1'b1;

    // Load every word so reads have defined contents.
    for (int i = 0; i < DEPTH; i++) begin
      fill_en   = 1'b1;
      fill_idx  = IW'(i);
      fill_data = rand128();
      step();
    end
    // Fill beyond the store must be dropped.
    fill_en   = 1'b1;
    fill_idx  = IW'(50);
    fill_data = rand128();
    step();

    // Basic read of idx 5, then low nibble ignored.
    fill_en   = 1'b1;
    fill_idx  = IW'(5);
    fill_data = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    step();
    do_read(BASE + 32'h50, 1'b0, 1'b0, 128'd0, 1'b0);
    do_read(BASE + 32'h5F, 1'b0, 1'b0, 128'd0, 1'b0);

    // Window edges.
    do_read(BASE + DEPTH * 16, 1'b0, 1'b0, 128'd0, 1'b0);
    do_read(BASE - 32'd16, 1'b0, 1'b0, 128'd0, 1'b0);
    do_read(BASE + DEPTH * 16 - 1, 1'b0, 1'b0, 128'd0, 1'b0);
    do_read(BASE, 1'b0, 1'b0, 128'd0, 1'b0);

    // Request held high across three back-to-back transactions.
    do_read(BASE + 32'h10, 1'b1, 1'b0, 128'd0, 1'b0);
    do_read(BASE + 32'h20, 1'b1, 1'b0, 128'd0, 1'b0);
    do_read(BASE + 32'h30, 1'b0, 1'b0, 128'd0, 1'b0);

    // Write-first forwarding on the ack edge.
    fill_en   = 1'b1;
    fill_idx  = IW'(7);
    fill_data = {4{32'hAAAA_0007}};
    step();
    do_read(BASE + 32'h70, 1'b0, 1'b1, {4{32'hBBBB_0007}}, 1'b0);

    // Reset while waiting: request dropped, store kept.
    mem_req  = 1'b1;
    mem_addr = BASE + 32'h70;
    step();
    mem_req = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("midreset_busy", {127'd0, busy}, 128'd0);
    check("midreset_served_cnt", {112'd0, served_cnt}, 128'd0);
    check("midreset_ack", {127'd0, mem_ack}, 128'd0);
    repeat (2) step();
    rst_n   = 1'b1;
    ref_cnt = 16'd0;
    do_read(BASE + 32'h70, 1'b0, 1'b0, 128'd0, 1'b0);

    // Randomized traffic mixing windows, holds, idle gaps and fills.
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = BASE + 32'($urandom_range(0, DEPTH * 16 - 1));
      else if (sel == 7) a = BASE - 32'($urandom_range(1, 256));
      else if (sel == 8) a = BASE + DEPTH * 16 + 32'($urandom_range(0, 4096));
      else               a = $urandom;
      hold = (n != 39) && ($urandom_range(0, 2) == 0);
      do_read(a, hold, $urandom_range(0, 3) == 0, rand128(), 1'b1);
      if (!hold) repeat ($urandom_range(0, 2)) step();
    end

    for (int w = 0; w < 10 && sb.size() != 0; w++) step();
    check("scoreboard_drained", 128'(sb.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
